// File: rtl/riscv_multicycle_fsm.sv
// Main control FSM of the multicycle RISC-V core.
// Sequences fetch/decode/execute/memory/writeback over the shared datapath.
module riscv_multicycle_fsm #(
    parameter int ST_W = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [6:0]      opcode,
    input  logic [2:0]      Funct3,
    input  logic [6:0]      Funct7,
    input  logic            zero,
    input  logic            mem_ready,
    output logic            PCWrite,
    output logic            AdrSrc,
    output logic            IRWrite,
    output logic            MemWrite,
    output logic            RegWrite,
    output logic [1:0]      ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic [1:0]      ResultSrc,
    output logic [2:0]      ImmSrc,
    output logic [3:0]      ALUOp,
    output logic            illegal_op,
    output logic [ST_W-1:0] state_o
);

    typedef enum logic [ST_W-1:0] {
        FETCH    = ST_W'(0),
        DECODE   = ST_W'(1),
        MEMADR   = ST_W'(2),
        MEMREAD  = ST_W'(3),
        MEMWB    = ST_W'(4),
        MEMWRITE = ST_W'(5),
        EXECR    = ST_W'(6),
        EXECI    = ST_W'(7),
        ALUWB    = ST_W'(8),
        BRANCH   = ST_W'(9),
        JAL      = ST_W'(10),
        JALR     = ST_W'(11),
        JLINK    = ST_W'(12),
        AUIPC    = ST_W'(13)
    } state_t;

    localparam logic [6:0] OP_LW    = 7'h03;
    localparam logic [6:0] OP_SW    = 7'h23;
    localparam logic [6:0] OP_R     = 7'h33;
    localparam logic [6:0] OP_I     = 7'h13;
    localparam logic [6:0] OP_BR    = 7'h63;
    localparam logic [6:0] OP_JAL   = 7'h6F;
    localparam logic [6:0] OP_JALR  = 7'h67;
    localparam logic [6:0] OP_AUIPC = 7'h17;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0011;
    localparam logic [3:0] ALU_MUL = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b0100;
    localparam logic [3:0] ALU_SRL = 4'b0101;
    localparam logic [3:0] ALU_SLT = 4'b0110;

    state_t state, next;
    logic   pc_write, ir_write, mem_write, reg_write, illegal;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= FETCH;
        else        state <= next;
    end

    always_comb begin
        next      = FETCH;
        pc_write  = 1'b0;
        ir_write  = 1'b0;
        mem_write = 1'b0;
        reg_write = 1'b0;
        illegal   = 1'b0;
        AdrSrc    = 1'b0;
        ALUSrcA   = 2'b00;
        ALUSrcB   = 2'b00;
        ResultSrc = 2'b00;
        ImmSrc    = 3'b000;
        ALUOp     = ALU_ADD;
        case (state)
            FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                pc_write  = mem_ready;
                ir_write  = mem_ready;
                next      = mem_ready ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                if (opcode == OP_BR)       ImmSrc = 3'b010;
                else if (opcode == OP_JAL) ImmSrc = 3'b011;
                case (opcode)
                    OP_LW, OP_SW: next = MEMADR;
                    OP_R:         next = EXECR;
                    OP_I:         next = EXECI;
                    OP_BR:        next = BRANCH;
                    OP_JAL:       next = JAL;
                    OP_JALR:      next = JALR;
                    OP_AUIPC:     next = AUIPC;
                    default: begin
                        illegal = 1'b1;
                        next    = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                ImmSrc  = (opcode == OP_SW) ? 3'b001 : 3'b000;
                next    = (opcode == OP_SW) ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                AdrSrc = 1'b1;
                next   = mem_ready ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                ResultSrc = 2'b01;
                reg_write = 1'b1;
            end
            MEMWRITE: begin
                AdrSrc    = 1'b1;
                mem_write = 1'b1;
                next      = mem_ready ? FETCH : MEMWRITE;
            end
            EXECR: begin
                ALUSrcA = 2'b10;
                case (Funct7)
                    7'b0000001: ALUOp = ALU_MUL;
                    7'b0100000: ALUOp = ALU_SUB;
                    default:    ALUOp = ALU_ADD;
                endcase
                next = ALUWB;
            end
            EXECI: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                case (Funct3)
                    3'b001:  ALUOp = ALU_SLL;
                    3'b101:  ALUOp = ALU_SRL;
                    3'b010:  ALUOp = ALU_SLT;
                    default: ALUOp = ALU_ADD;
                endcase
                next = ALUWB;
            end
            ALUWB: reg_write = 1'b1;
            BRANCH: begin
                ALUSrcA  = 2'b10;
                ALUOp    = ALU_SUB;
                pc_write = ((Funct3 == 3'b000) & zero) |
                           ((Funct3 == 3'b001) & ~zero);
            end
            JAL: begin
                ALUSrcA  = 2'b01;
                ALUSrcB  = 2'b10;
                pc_write = 1'b1;
                next     = ALUWB;
            end
            JALR: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                pc_write  = 1'b1;
                next      = JLINK;
            end
            // rs1 was consumed in JALR, so rd == rs1 is safe here
            JLINK: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                reg_write = 1'b1;
            end
            AUIPC: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                ImmSrc  = 3'b100;
                next    = ALUWB;
            end
            default: next = FETCH;
        endcase
    end

    assign PCWrite    = pc_write & reset;
    assign IRWrite    = ir_write & reset;
    assign MemWrite   = mem_write & reset;
    assign RegWrite   = reg_write & reset;
    assign illegal_op = illegal & reset;
    assign state_o    = state;

endmodule
